// File: rtl/lsu_pkg.sv
// lsu_pkg: shared widths, memory depth and FSM state codes
// for the load/store controller.
`ifndef DATA_ROW
`define DATA_ROW 256
`endif
`ifndef DATA_COLUMN
`define DATA_COLUMN 16
`endif

package lsu_pkg;
  localparam int LSU_ADDR_W    = 16;
  localparam int LSU_DATA_W    = `DATA_COLUMN;
  localparam int LSU_MEM_DEPTH = `DATA_ROW;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_ACCESS = 2'd1;
  localparam state_t S_RESP   = 2'd2;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-word load/store controller between execute
// and data memory, with range check and saturating error count.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = LSU_ADDR_W,
  parameter int DATA_W    = LSU_DATA_W,
  parameter int MEM_DEPTH = LSU_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_read_data
);
  localparam logic [ADDR_W:0] DEPTH_C =
    (ADDR_W+1)'(MEM_DEPTH);

  state_t              state_q;
  state_t              state_d;
  logic                we_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [15:0]         cnt_q;
  logic                accept;
  logic                access;
  logic                addr_err;

  assign req_ready = (state_q == S_IDLE) ||
                     ((state_q == S_RESP) && resp_ready);
  assign accept    = req_valid && req_ready;
  assign access    = (state_q == S_ACCESS);
  assign addr_err  = ({1'b0, req_addr} >= DEPTH_C);

  // Next state: one access cycle, then hold the response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP: begin
        if (resp_ready)
          state_d = req_valid ? S_ACCESS : S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // State register and request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= addr_err;
      end
    end
  end

  // Capture load data at the end of the access cycle.
  always_ff @(posedge clk) begin
    if (rst)
      rdata_q <= '0;
    else if (access)
      rdata_q <= (!we_q && !err_q) ? mem_read_data : '0;
  end

  // Error counter; reloaded every cycle so it only
  // ever changes by increment or reset.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= (access && err_q) ? sat_inc(cnt_q) : cnt_q;
  end

  assign resp_valid     = (state_q == S_RESP);
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;
  assign err_count      = cnt_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_write_en   = access && !err_q && we_q && !rst;
  assign mem_read_en    = access && !err_q && !we_q && !rst;
endmodule
